edge_event_arbiter: RTL and testbench

Multi-channel edge-event scheduler. Each channel synchronizes one asynchronous input, detects its rising and falling edges, and holds them as pending requests. A round-robin arbiter shares a single valid/ready event port among all channels, and a sticky per-channel overflow flag records any events that had to be dropped. It sits between raw board-level signals (keys, interrupts, strobes) and a single downstream consumer such as a CPU event register or UART reporter.

---
 rtl/edge_event_arbiter.sv | 110 +++++++++++
 tb/tb_edge_event_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge capture with pending bits,
// round-robin grant onto one registered valid/ready event port.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig_in,
  input  logic [N_CH-1:0] rise_en,
  input  logic [N_CH-1:0] fall_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  logic [N_CH-1:0] s1, s2, sd;
  logic [N_CH-1:0] pr, pf;
  logic [N_CH-1:0] rise_det, fall_det, req;
  logic [N_CH-1:0] clr_r, clr_f;
  logic [N_CH-1:0] pr_nxt, pf_nxt, ovf_set;
  logic [CH_W-1:0] last, gnt;
  logic [CH_W:0]   j;
  logic            found, gnt_rise, load;

  assign rise_det = s2 & ~sd & rise_en;
  assign fall_det = ~s2 & sd & fall_en;
  assign req      = pr | pf;
  assign load     = ~evt_valid | evt_ready;

  // search upward from the channel after last, wrapping once
  always_comb begin
    found = 1'b0;
    gnt   = last;
    j     = '0;
    for (int i = 1; i <= N_CH; i++) begin
      j = {1'b0, last} + (CH_W+1)'(i);
      if (j >= (CH_W+1)'(N_CH))
        j = j - (CH_W+1)'(N_CH);
      if (!found && req[j[CH_W-1:0]]) begin
        found = 1'b1;
        gnt   = j[CH_W-1:0];
      end
    end
  end

  // pick the older edge type and derive pending/overflow updates
  always_comb begin
    gnt_rise = pr[gnt] & (~pf[gnt] | ~s2[gnt]);
    clr_r    = '0;
    clr_f    = '0;
    if (load && found) begin
      if (gnt_rise)
        clr_r[gnt] = 1'b1;
      else
        clr_f[gnt] = 1'b1;
    end
    pr_nxt  = (pr & ~clr_r) | rise_det;
    pf_nxt  = (pf & ~clr_f) | fall_det;
    ovf_set = (rise_det & pr & ~clr_r)
            | (fall_det & pf & ~clr_f);
  end

  // two-flop synchronizer plus delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      sd <= '0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      sd <= s2;
    end
  end

  // pending bits and sticky overflow; a new set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr  <= '0;
      pf  <= '0;
      ovf <= '0;
    end else begin
      pr  <= pr_nxt;
      pf  <= pf_nxt;
      ovf <= (ovf & {N_CH{~ovf_clr}}) | ovf_set;
    end
  end

  // registered event port; payload only moves when the port is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      last      <= CH_W'(N_CH - 1);
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_ch   <= gnt;
        evt_rise <= gnt_rise;
        last     <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed and random stimulus, behavioural
// model feeding a scoreboard queue checked by a separate monitor.
module tb_edge_event_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sig_in = '0;
  logic [N-1:0] rise_en = '1;
  logic [N-1:0] fall_en = '1;
  logic         evt_valid;
  logic         evt_ready = 1'b1;
  logic [W-1:0] evt_ch;
  logic         evt_rise;
  logic [N-1:0] ovf;
  logic         ovf_clr = 1'b0;

  edge_event_arbiter #(.N_CH(N), .CH_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .sig_in(sig_in), .rise_en(rise_en), .fall_en(fall_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_rise(evt_rise),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; bit rise; } ev_t;
  ev_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference model state: sampled history and pending sets per channel
  int  h1[N], h2[N], h3[N];
  int  m_pr[N], m_pf[N], m_ovf[N];
  int  m_dr[N], m_df[N];
  int  m_last = N - 1;
  bit  m_valid = 1'b0;
  int  g_ch;
  bit  g_rise, g_found, g_load;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < N; c++) begin
          h1[c] = 0; h2[c] = 0; h3[c] = 0;
          m_pr[c] = 0; m_pf[c] = 0; m_ovf[c] = 0;
        end
        m_last  = N - 1;
        m_valid = 1'b0;
        sb.delete();
      end else begin
        for (int c = 0; c < N; c++) begin
          m_dr[c] = (h2[c] == 1 && h3[c] == 0 && rise_en[c]) ? 1 : 0;
          m_df[c] = (h2[c] == 0 && h3[c] == 1 && fall_en[c]) ? 1 : 0;
        end
        g_load  = !m_valid || evt_ready;
        g_found = 1'b0;
        g_ch    = 0;
        g_rise  = 1'b0;
        if (g_load) begin
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!g_found && (m_pr[c] != 0 || m_pf[c] != 0)) begin
              g_found = 1'b1;
              g_ch    = c;
            end
          end
          if (g_found) begin
            if (m_pr[g_ch] != 0 && m_pf[g_ch] != 0)
              g_rise = (h2[g_ch] == 0);
            else
              g_rise = (m_pr[g_ch] != 0);
            if (g_rise) m_pr[g_ch] = 0;
            else m_pf[g_ch] = 0;
            m_last = g_ch;
            sb.push_back('{ch: g_ch, rise: g_rise});
          end
          m_valid = g_found;
        end
        if (ovf_clr)
          for (int c = 0; c < N; c++) m_ovf[c] = 0;
        for (int c = 0; c < N; c++) begin
          if (m_dr[c] != 0) begin
            if (m_pr[c] != 0) m_ovf[c] = 1;
            m_pr[c] = 1;
          end
          if (m_df[c] != 0) begin
            if (m_pf[c] != 0) m_ovf[c] = 1;
            m_pf[c] = 1;
          end
        end
        for (int c = 0; c < N; c++) begin
          h3[c] = h2[c];
          h2[c] = h1[c];
          h1[c] = int'(sig_in[c]);
        end
      end
    end
  end

  // monitor: port state must match the scoreboard head every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int e;
        chk("valid", int'(evt_valid), (sb.size() != 0) ? 1 : 0);
        if (evt_valid && sb.size() != 0) begin
          chk("evt_ch", int'(evt_ch), sb[0].ch);
          chk("evt_rise", int'(evt_rise), int'(sb[0].rise));
          if (evt_ready) void'(sb.pop_front());
        end
        e = 0;
        for (int c = 0; c < N; c++)
          if (m_ovf[c] != 0) e = e | (1 << c);
        chk("ovf", int'(ovf), e);
      end
    end
  end

  int hold[N];

  initial begin
    rst_n = 1'b0;
    tick(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ch", int'(evt_ch), 0);
    chk("rst_rise", int'(evt_rise), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    tick(4);

    // single edge pair on channel 2
    sig_in[2] = 1'b1; tick(5);
    sig_in[2] = 1'b0; tick(8);

    // simultaneous requests under backpressure
    evt_ready = 1'b0;
    sig_in = 4'b1011; tick(6);
    evt_ready = 1'b1; tick(6);
    sig_in[1] = 1'b0; tick(6);
    evt_ready = 1'b0;
    sig_in[0] = 1'b0; sig_in[3] = 1'b0; tick(6);
    evt_ready = 1'b1; tick(6);

    // long stall with a rise and fall queued on channel 1
    evt_ready = 1'b0;
    sig_in[1] = 1'b1; tick(4);
    sig_in[1] = 1'b0; tick(20);
    evt_ready = 1'b1; tick(6);

    // overflow on channel 0 while the port is held by channel 3
    evt_ready = 1'b0;
    sig_in[3] = 1'b1; tick(6);
    sig_in[0] = 1'b1; tick(4);
    sig_in[0] = 1'b0; tick(4);
    sig_in[0] = 1'b1; tick(4);
    sig_in[0] = 1'b0; tick(6);
    chk("ovf_set", int'(ovf), 1);
    evt_ready = 1'b1; tick(6);
    ovf_clr = 1'b1; tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);
    sig_in[3] = 1'b0; tick(6);

    // rising edges masked on channel 2
    rise_en[2] = 1'b0;
    sig_in[2] = 1'b1; tick(5);
    sig_in[2] = 1'b0; tick(6);
    rise_en[2] = 1'b1;

    // ch3 rise detected on the cycle its pending rise is granted
    evt_ready = 1'b0;
    sig_in[1] = 1'b1; tick(6);
    fall_en[3] = 1'b0;
    sig_in[3] = 1'b1; tick(5);
    sig_in[3] = 1'b0; tick(4);
    sig_in[3] = 1'b1; tick(2);
    evt_ready = 1'b1; tick(6);
    chk("collide_ovf3", int'(ovf[3]), 0);
    fall_en = '1;
    sig_in = '0; tick(8);

    // asynchronous reset with an event presented and more pending
    evt_ready = 1'b0;
    sig_in[0] = 1'b1; sig_in[2] = 1'b1; tick(6);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(evt_valid), 0);
    chk("arst_ch", int'(evt_ch), 0);
    chk("arst_ovf", int'(ovf), 0);
    sig_in = '0;
    tick(3);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    tick(12);

    // random traffic
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          if ($urandom_range(0, 3) == 0) sig_in[c] = ~sig_in[c];
          hold[c] = $urandom_range(2, 10);
        end else begin
          hold[c]--;
        end
      end
      evt_ready = ($urandom_range(0, 9) < 7);
      ovf_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rise_en = 4'($urandom);
        fall_en = 4'($urandom);
      end
      tick(1);
    end

    // drain everything still pending
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    tick(30);
    chk("drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
